// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled pattern tick, tick-sampled mode selection and
// four display modes (off, blink, chase, PWM breathe) driving a registered LED bus.
module led_pattern_gen #(
  parameter int N_LEDS   = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter int PWM_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              mode_chg,
  output logic              tick,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        dbg_mode
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_CHASE   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_MAX   = DIV_W'(TICK_DIV - 1);
  localparam logic [N_LEDS-1:0]   POS_INIT  = N_LEDS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                tick_q, tick_d;
  mode_e               mode_q, mode_d;
  mode_e               mode_sel;
  logic                mode_chg_q, mode_chg_d;
  logic                phase_q, phase_d;
  logic [N_LEDS-1:0]   pos_q, pos_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_down_q, dir_down_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_LEDS-1:0]   led_q, led_d;

  assign mode_sel = mode_e'(mode);

  // Prescaler and PWM counter both stall while en is low.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;
    pwm_cnt_d = pwm_cnt_q;
    if (en) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (div_cnt_q == DIV_MAX) begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // A tick that was already issued is consumed even if en has just dropped.
  always_comb begin
    mode_d     = mode_q;
    mode_chg_d = 1'b0;
    phase_d    = phase_q;
    pos_d      = pos_q;
    duty_d     = duty_q;
    dir_down_d = dir_down_q;
    if (tick_q) begin
      if (mode_sel != mode_q) begin
        mode_d     = mode_sel;
        mode_chg_d = 1'b1;
        case (mode_sel)
          MODE_BLINK:   phase_d = 1'b1;
          MODE_CHASE:   pos_d   = POS_INIT;
          MODE_BREATHE: begin
            duty_d     = '0;
            dir_down_d = 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (mode_q)
          MODE_BLINK: phase_d = ~phase_q;
          MODE_CHASE: pos_d   = (pos_q << 1) | (pos_q >> (N_LEDS - 1));
          MODE_BREATHE: begin
            // Turn around on the extreme value so each end appears once per period.
            if (!dir_down_q) begin
              if (duty_q == DUTY_MAX) begin
                dir_down_d = 1'b1;
                duty_d     = duty_q - 1'b1;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                dir_down_d = 1'b0;
                duty_d     = duty_q + 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    led_d = led_q;
    if (en) begin
      case (mode_q)
        MODE_OFF:     led_d = '0;
        MODE_BLINK:   led_d = {N_LEDS{phase_q}};
        MODE_CHASE:   led_d = pos_q;
        MODE_BREATHE: led_d = {N_LEDS{pwm_cnt_q < duty_q}};
        default:      led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      tick_q     <= 1'b0;
      mode_q     <= MODE_OFF;
      mode_chg_q <= 1'b0;
      phase_q    <= 1'b0;
      pos_q      <= POS_INIT;
      duty_q     <= '0;
      dir_down_q <= 1'b0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tick_q     <= tick_d;
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      duty_q     <= duty_d;
      dir_down_q <= dir_down_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
    end
  end

  assign tick     = tick_q;
  assign mode_chg = mode_chg_q;
  assign led      = led_q;
  assign dbg_mode = mode_q;

endmodule
